// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - collapsing out-of-order ALU issue queue
// Oldest-ready select with external and self wakeup; entry 0 is always the oldest.
module alu_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = 6,
   parameter int PAYLOAD_W = 128,
   parameter int WAKE_N    = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       dispatch_valid,
   output logic                       iq_allowin,
   input  logic [PAYLOAD_W-1:0]       dispatch_payload,
   input  logic [TAG_W-1:0]           dispatch_dest,
   input  logic                       dispatch_rf_we,
   input  logic [TAG_W-1:0]           dispatch_src1,
   input  logic [TAG_W-1:0]           dispatch_src2,
   input  logic                       dispatch_src1_rdy,
   input  logic                       dispatch_src2_rdy,
   input  logic [WAKE_N-1:0]          wakeup_valid,
   input  logic [WAKE_N*TAG_W-1:0]    wakeup_tag,
   output logic                       issue_to_alu_valid,
   output logic [PAYLOAD_W-1:0]       issue_payload,
   output logic [TAG_W-1:0]           issue_dest,
   output logic                       issue_wakeup_valid,
   output logic [$clog2(DEPTH+1)-1:0] iq_count
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int SRC_N = WAKE_N + 1;

   logic [CNT_W-1:0]     r_count;
   logic [PAYLOAD_W-1:0] r_payload [DEPTH];
   logic [TAG_W-1:0]     r_dest    [DEPTH];
   logic [TAG_W-1:0]     r_src1    [DEPTH];
   logic [TAG_W-1:0]     r_src2    [DEPTH];
   logic [DEPTH-1:0]     r_we;
   logic [DEPTH-1:0]     r_rdy1;
   logic [DEPTH-1:0]     r_rdy2;

   logic [DEPTH-1:0]       w_ready;
   logic [DEPTH-1:0]       w_sel_oh;
   logic [DEPTH-1:0]       w_shift;
   logic                   w_found;
   logic [DEPTH-1:0]       w_wake1;
   logic [DEPTH-1:0]       w_wake2;
   logic                   w_dwake1;
   logic                   w_dwake2;
   logic                   w_accept;
   logic [IDX_W-1:0]       w_wr_idx;
   logic [SRC_N-1:0]       w_wk_vld;
   logic [SRC_N*TAG_W-1:0] w_wk_tags;

   function automatic logic f_match(input logic [TAG_W-1:0] tag,
                                    input logic [SRC_N-1:0] vld,
                                    input logic [SRC_N*TAG_W-1:0] tags);
      f_match = 1'b0;
      for (int k = 0; k < SRC_N; k++) begin
         if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) f_match = 1'b1;
      end
   endfunction

   // Self-wakeup is the top source so a dependent can issue the very next cycle.
   assign w_wk_vld  = {issue_wakeup_valid, wakeup_valid};
   assign w_wk_tags = {issue_dest, wakeup_tag};

   assign iq_allowin = (r_count < CNT_W'(DEPTH));
   assign iq_count   = r_count;
   assign w_accept   = dispatch_valid & iq_allowin;
   assign w_wr_idx   = IDX_W'(r_count - CNT_W'(w_found));
   assign w_dwake1   = f_match(dispatch_src1, w_wk_vld, w_wk_tags);
   assign w_dwake2   = f_match(dispatch_src2, w_wk_vld, w_wk_tags);

   always_comb begin
      w_sel_oh = '0;
      w_shift  = '0;
      w_found  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i] = (CNT_W'(i) < r_count) & r_rdy1[i] & r_rdy2[i];
         if (!w_found && w_ready[i]) begin
            w_sel_oh[i] = 1'b1;
            w_found     = 1'b1;
         end
         w_shift[i] = w_found;
      end
   end

   always_comb begin
      issue_to_alu_valid = w_found;
      issue_payload      = '0;
      issue_dest         = '0;
      issue_wakeup_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_sel_oh[i]) begin
            issue_payload      = r_payload[i];
            issue_dest         = r_dest[i];
            issue_wakeup_valid = r_we[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_wake1[i] = f_match(r_src1[i], w_wk_vld, w_wk_tags);
         w_wake2[i] = f_match(r_src2[i], w_wk_vld, w_wk_tags);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_count <= '0;
      end else begin
         // Entries at or above the issued slot collapse down, picking up same-cycle wakeups.
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_shift[i]) begin
               r_payload[i] <= r_payload[i+1];
               r_dest[i]    <= r_dest[i+1];
               r_src1[i]    <= r_src1[i+1];
               r_src2[i]    <= r_src2[i+1];
               r_we[i]      <= r_we[i+1];
               r_rdy1[i]    <= r_rdy1[i+1] | w_wake1[i+1];
               r_rdy2[i]    <= r_rdy2[i+1] | w_wake2[i+1];
            end else begin
               r_rdy1[i]    <= r_rdy1[i] | w_wake1[i];
               r_rdy2[i]    <= r_rdy2[i] | w_wake2[i];
            end
         end
         r_rdy1[DEPTH-1] <= r_rdy1[DEPTH-1] | w_wake1[DEPTH-1];
         r_rdy2[DEPTH-1] <= r_rdy2[DEPTH-1] | w_wake2[DEPTH-1];
         for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && w_wr_idx == IDX_W'(i)) begin
               r_payload[i] <= dispatch_payload;
               r_dest[i]    <= dispatch_dest;
               r_src1[i]    <= dispatch_src1;
               r_src2[i]    <= dispatch_src2;
               r_we[i]      <= dispatch_rf_we;
               r_rdy1[i]    <= dispatch_src1_rdy | w_dwake1;
               r_rdy2[i]    <= dispatch_src2_rdy | w_dwake2;
            end
         end
         r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_found);
      end
   end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed self-checking bench for alu_issue_queue
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_alu_issue_queue;
   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         dispatch_valid;
   logic         iq_allowin;
   logic [127:0] dispatch_payload;
   logic [5:0]   dispatch_dest;
   logic         dispatch_rf_we;
   logic [5:0]   dispatch_src1;
   logic [5:0]   dispatch_src2;
   logic         dispatch_src1_rdy;
   logic         dispatch_src2_rdy;
   logic [2:0]   wakeup_valid;
   logic [17:0]  wakeup_tag;
   logic         issue_to_alu_valid;
   logic [127:0] issue_payload;
   logic [5:0]   issue_dest;
   logic         issue_wakeup_valid;
   logic [3:0]   iq_count;

   int n_cmp = 0;
   int n_mis = 0;

   alu_issue_queue #(.DEPTH(8), .TAG_W(6), .PAYLOAD_W(128), .WAKE_N(3)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dispatch_valid(dispatch_valid), .iq_allowin(iq_allowin),
      .dispatch_payload(dispatch_payload), .dispatch_dest(dispatch_dest),
      .dispatch_rf_we(dispatch_rf_we),
      .dispatch_src1(dispatch_src1), .dispatch_src2(dispatch_src2),
      .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
      .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
      .issue_to_alu_valid(issue_to_alu_valid), .issue_payload(issue_payload),
      .issue_dest(issue_dest), .issue_wakeup_valid(issue_wakeup_valid),
      .iq_count(iq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dispatch_valid = 1'b0;
      wakeup_valid   = '0;
      wakeup_tag     = '0;
      flush          = 1'b0;
   endtask

   task automatic disp(input logic [127:0] pl, input logic [5:0] dst, input logic we,
                       input logic [5:0] s1, input logic r1, input logic [5:0] s2, input logic r2);
      dispatch_valid    = 1'b1;
      dispatch_payload  = pl;
      dispatch_dest     = dst;
      dispatch_rf_we    = we;
      dispatch_src1     = s1;
      dispatch_src1_rdy = r1;
      dispatch_src2     = s2;
      dispatch_src2_rdy = r2;
   endtask

   task automatic wake(input int k, input logic [5:0] tag);
      wakeup_valid[k]       = 1'b1;
      wakeup_tag[k*6 +: 6]  = tag;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      disp(128'h0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
      dispatch_valid = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_count", iq_count, 0);
      chk("rst_allowin", iq_allowin, 1);
      chk("rst_valid", issue_to_alu_valid, 0);
      chk("rst_payload", issue_payload, 0);
      chk("rst_wkv", issue_wakeup_valid, 0);

      // 1: back-to-back ready ops
      disp(128'hA, 6'd1, 1'b0, 6'd2, 1'b1, 6'd3, 1'b1);
      tick();
      chk("t1_a_valid", issue_to_alu_valid, 1);
      chk("t1_a_payload", issue_payload, 128'hA);
      chk("t1_count1", iq_count, 1);
      disp(128'hB, 6'd4, 1'b0, 6'd2, 1'b1, 6'd3, 1'b1);
      tick();
      chk("t1_b_payload", issue_payload, 128'hB);
      chk("t1_count_b", iq_count, 1);
      idle();
      tick();
      chk("t1_count0", iq_count, 0);
      chk("t1_idle_valid", issue_to_alu_valid, 0);

      // 2: self-wakeup, dependent dispatched while producer issues
      disp(128'h2A, 6'd5, 1'b1, 6'd1, 1'b1, 6'd1, 1'b1);
      tick();
      chk("t2_a_wkv", issue_wakeup_valid, 1);
      chk("t2_a_dest", issue_dest, 5);
      disp(128'h2B, 6'd7, 1'b0, 6'd5, 1'b0, 6'd1, 1'b1);
      tick();
      chk("t2_b_valid", issue_to_alu_valid, 1);
      chk("t2_b_payload", issue_payload, 128'h2B);
      chk("t2_b_wkv", issue_wakeup_valid, 0);
      idle();
      tick();
      chk("t2_count0", iq_count, 0);

      // 3: younger ready op bypasses older waiting op, then bus0 wakeup
      disp(128'h3C, 6'd8, 1'b0, 6'd1, 1'b1, 6'd9, 1'b0);
      tick();
      chk("t3_c_wait", issue_to_alu_valid, 0);
      chk("t3_count1", iq_count, 1);
      disp(128'h3D, 6'd10, 1'b0, 6'd1, 1'b1, 6'd1, 1'b1);
      tick();
      chk("t3_d_first", issue_payload, 128'h3D);
      chk("t3_count2", iq_count, 2);
      idle();
      wake(0, 6'd9);
      tick();
      chk("t3_c_next", issue_payload, 128'h3C);
      chk("t3_count_c", iq_count, 1);
      idle();
      tick();
      chk("t3_count0", iq_count, 0);

      // 4: fill, blocked dispatch, wakeup of middle entry, ordered drain
      for (int i = 0; i < 8; i++) begin
         disp(128'h100 + 128'(i), 6'd40, 1'b0, 6'(20 + i), 1'b0, 6'd1, 1'b1);
         tick();
      end
      chk("t4_full_count", iq_count, 8);
      chk("t4_full_allowin", iq_allowin, 0);
      chk("t4_full_valid", issue_to_alu_valid, 0);
      disp(128'hFF, 6'd41, 1'b0, 6'd1, 1'b1, 6'd1, 1'b1);
      tick();
      chk("t4_blocked_count", iq_count, 8);
      chk("t4_blocked_valid", issue_to_alu_valid, 0);
      idle();
      wake(1, 6'd23);
      tick();
      chk("t4_e3_payload", issue_payload, 128'h103);
      chk("t4_e3_allowin", iq_allowin, 0);
      idle();
      tick();
      chk("t4_after_count", iq_count, 7);
      chk("t4_after_allowin", iq_allowin, 1);
      chk("t4_after_valid", issue_to_alu_valid, 0);
      wake(0, 6'd20);
      wake(1, 6'd21);
      wake(2, 6'd22);
      tick();
      chk("t4_d0", issue_payload, 128'h100);
      idle();
      tick();
      chk("t4_d1", issue_payload, 128'h101);
      tick();
      chk("t4_d2", issue_payload, 128'h102);
      tick();
      chk("t4_rest_count", iq_count, 4);
      chk("t4_rest_valid", issue_to_alu_valid, 0);
      do_reset();
      chk("t4_reset_count", iq_count, 0);

      // 5: wakeup in the dispatch cycle; shared source tag
      disp(128'h5E, 6'd11, 1'b0, 6'd12, 1'b0, 6'd1, 1'b1);
      wake(2, 6'd12);
      tick();
      chk("t5_e_payload", issue_payload, 128'h5E);
      idle();
      tick();
      disp(128'h5F, 6'd11, 1'b0, 6'd30, 1'b0, 6'd30, 1'b0);
      tick();
      chk("t5_same_wait", issue_to_alu_valid, 0);
      idle();
      wake(1, 6'd30);
      tick();
      chk("t5_same_payload", issue_payload, 128'h5F);
      idle();
      tick();
      chk("t5_count0", iq_count, 0);

      // 6: flush beats a concurrent dispatch
      for (int i = 0; i < 5; i++) begin
         disp(128'h600 + 128'(i), 6'd2, 1'b0, 6'd40, 1'b0, 6'd1, 1'b1);
         tick();
      end
      chk("t6_count5", iq_count, 5);
      disp(128'h6FF, 6'd2, 1'b1, 6'd1, 1'b1, 6'd1, 1'b1);
      flush = 1'b1;
      tick();
      chk("t6_flush_count", iq_count, 0);
      chk("t6_flush_valid", issue_to_alu_valid, 0);
      chk("t6_flush_allowin", iq_allowin, 1);
      idle();
      tick();
      chk("t6_dropped_count", iq_count, 0);
      chk("t6_dropped_valid", issue_to_alu_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
